// File: rtl/option_queue_sched.sv
// option_queue_sched: circular option queue feeding the line solver.
// Parser loads markers/options in IDLE; start sequences solving rounds.
// Ports: clk, rst (sync, active-high); load_valid/ready/is_line/data
// (parser load); start; opt_valid/ready/is_line/data (head to solver);
// resp_valid/keep, solved (solver verdicts); busy, done, stalled,
// empty_err, round_cnt (status).
// Define OPTQ_PERF_CNT_EN to add run_cycles and dropped_total outputs.
module option_queue_sched #(
  parameter int SIZE       = 3,
  parameter int LINES      = 6,
  parameter int DEPTH      = 64,
  parameter int MAX_ROUNDS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            load_is_line,
  input  logic [SIZE-1:0] load_data,
  input  logic            start,
  output logic            opt_valid,
  input  logic            opt_ready,
  output logic            opt_is_line,
  output logic [SIZE-1:0] opt_data,
  input  logic            resp_valid,
  input  logic            resp_keep,
  input  logic            solved,
  output logic            busy,
  output logic            done,
  output logic            stalled,
  output logic            empty_err,
  output logic [7:0]      round_cnt
`ifdef OPTQ_PERF_CNT_EN
  ,
  output logic [15:0]     run_cycles,
  output logic [15:0]     dropped_total
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  logic [SIZE:0]   mem_q [DEPTH];
  state_t          state_q, state_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SIZE:0]   held_q, held_d;
  logic [7:0]      mk_q, mk_d;
  logic            drop_q, drop_d;
  logic [7:0]      round_q, round_d;
  logic            stalled_q, stalled_d;
  logic            eerr_q, eerr_d;
  logic            wr_en;
  logic [SIZE:0]   wr_data;
  logic [SIZE:0]   head_ent;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_ent   = mem_q[head_q];
  assign load_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  // Only a real head entry is ever presented; ISSUE on an empty
  // queue just terminates.
  assign opt_valid   = (state_q == S_ISSUE) && (count_q != '0);
  assign opt_is_line = opt_valid & head_ent[SIZE];
  assign opt_data    = opt_valid ? head_ent[SIZE-1:0] : '0;
  assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign stalled     = stalled_q;
  assign empty_err   = eerr_q;
  assign round_cnt   = round_q;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    held_d    = held_q;
    mk_d      = mk_q;
    drop_d    = drop_q;
    round_d   = round_q;
    stalled_d = stalled_q;
    eerr_d    = eerr_q;
    wr_en     = 1'b0;
    wr_data   = head_ent;
    unique case (state_q)
      S_IDLE: begin
        if (load_valid && load_ready) begin
          wr_en   = 1'b1;
          wr_data = {load_is_line, load_data};
          tail_d  = inc(tail_q);
          count_d = count_q + 1'b1;
        end
        if (start) begin
          if (count_q == '0) begin
            state_d = S_DONE;
            eerr_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (solved) begin
          state_d = S_DONE;
        end else if (count_q == '0) begin
          state_d = S_DONE;
          eerr_d  = 1'b1;
        end else if (opt_ready) begin
          head_d = inc(head_q);
          if (head_ent[SIZE]) begin
            // Marker rotates head to tail in one cycle.
            wr_en  = 1'b1;
            tail_d = inc(tail_q);
            if (mk_q == 8'(LINES - 1)) begin
              mk_d    = '0;
              drop_d  = 1'b0;
              round_d = (round_q == 8'hFF) ? round_q
                                           : round_q + 8'd1;
              if ((!drop_q && round_q != 8'd0) ||
                  round_d == 8'(MAX_ROUNDS)) begin
                state_d   = S_DONE;
                stalled_d = 1'b1;
              end
            end else begin
              mk_d = mk_q + 8'd1;
            end
          end else begin
            held_d  = head_ent;
            count_d = count_q - 1'b1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (solved) begin
          state_d = S_DONE;
        end else if (resp_valid) begin
          state_d = S_ISSUE;
          if (resp_keep) begin
            wr_en   = 1'b1;
            wr_data = held_q;
            tail_d  = inc(tail_q);
            count_d = count_q + 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      held_q    <= '0;
      mk_q      <= '0;
      drop_q    <= 1'b0;
      round_q   <= '0;
      stalled_q <= 1'b0;
      eerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      held_q    <= held_d;
      mk_q      <= mk_d;
      drop_q    <= drop_d;
      round_q   <= round_d;
      stalled_q <= stalled_d;
      eerr_q    <= eerr_d;
    end
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[tail_q] <= wr_data;
  end

`ifdef OPTQ_PERF_CNT_EN
  logic [15:0] run_q, drop_tot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q      <= '0;
      drop_tot_q <= '0;
    end else begin
      if (busy && run_q != 16'hFFFF)
        run_q <= run_q + 16'd1;
      if (state_q == S_WAIT && !solved && resp_valid &&
          !resp_keep && drop_tot_q != 16'hFFFF)
        drop_tot_q <= drop_tot_q + 16'd1;
    end
  end

  assign run_cycles    = run_q;
  assign dropped_total = drop_tot_q;
`endif

endmodule

// File: tb/tb_option_queue_sched.sv
// tb_option_queue_sched: vector tables plus queue scoreboard
// for option_queue_sched.
module tb_option_queue_sched;
  localparam int SIZE = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_valid, load_ready, load_is_line;
  logic [SIZE-1:0] load_data;
  logic            start;
  logic            opt_valid, opt_ready, opt_is_line;
  logic [SIZE-1:0] opt_data;
  logic            resp_valid, resp_keep, solved;
  logic            busy, done, stalled, empty_err;
  logic [7:0]      round_cnt;
`ifdef OPTQ_PERF_CNT_EN
  logic [15:0]     run_cycles, dropped_total;
`endif

  option_queue_sched dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_is_line(load_is_line), .load_data(load_data),
    .start(start),
    .opt_valid(opt_valid), .opt_ready(opt_ready),
    .opt_is_line(opt_is_line), .opt_data(opt_data),
    .resp_valid(resp_valid), .resp_keep(resp_keep),
    .solved(solved),
    .busy(busy), .done(done), .stalled(stalled),
    .empty_err(empty_err), .round_cnt(round_cnt)
`ifdef OPTQ_PERF_CNT_EN
    , .run_cycles(run_cycles), .dropped_total(dropped_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rdy, rv, keep, slv;
    logic e_valid, e_busy, e_done;
    logic [7:0] e_round;
  } vec_t;

  vec_t          vq[$];
  logic [SIZE:0] mq[$];
  logic [SIZE:0] mheld;
  int            nvec = 0;
  int            nerr = 0;

  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    load_valid = 0; load_is_line = 0; load_data = '0;
    start = 0; opt_ready = 0; resp_valid = 0;
    resp_keep = 0; solved = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst = 1;
    @(negedge clk);
    rst = 0;
    mq.delete();
  endtask

  task automatic load(bit tag, int d);
    @(negedge clk);
    idle_in();
    load_valid = 1;
    load_is_line = tag;
    load_data = d[SIZE-1:0];
    mq.push_back({tag, load_data});
  endtask

  task automatic do_start();
    @(negedge clk);
    idle_in();
    start = 1;
  endtask

  task automatic add(bit r, bit rv, bit k, bit s,
                     bit v, bit b, bit dn, int rd);
    vec_t t;
    t.rdy = r; t.rv = rv; t.keep = k; t.slv = s;
    t.e_valid = v; t.e_busy = b; t.e_done = dn;
    t.e_round = 8'(rd);
    vq.push_back(t);
  endtask

  // Pops the expected head and compares it with what the DUT presents.
  task automatic sb_pop(string nm, output logic [SIZE:0] e);
    if (mq.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: scoreboard empty, got tag %0d data %0d",
               nm, opt_is_line, opt_data);
      e = '0;
    end else begin
      e = mq.pop_front();
      chk({nm, ".tag"}, opt_is_line, e[SIZE]);
      chk({nm, ".data"}, opt_data, e[SIZE-1:0]);
    end
  endtask

  task automatic run_vecs(string nm);
    vec_t t;
    logic [SIZE:0] e;
    string s;
    for (int i = 0; i < vq.size(); i++) begin
      t = vq[i];
      @(negedge clk);
      idle_in();
      opt_ready = t.rdy; resp_valid = t.rv;
      resp_keep = t.keep; solved = t.slv;
      s = $sformatf("%s[%0d]", nm, i);
      chk({s, ".opt_valid"}, opt_valid, t.e_valid);
      chk({s, ".busy"}, busy, t.e_busy);
      chk({s, ".done"}, done, t.e_done);
      chk({s, ".round"}, round_cnt, t.e_round);
      if (t.e_valid && t.rdy && !t.slv) begin
        sb_pop(s, e);
        if (e[SIZE]) mq.push_back(e);
        else mheld = e;
      end else if (t.e_busy && !t.e_valid && t.rv &&
                   t.keep && !t.slv) begin
        mq.push_back(mheld);
      end
    end
    vq.delete();
  endtask

  task automatic chk_end(string nm, int dn, int st, int ee, int rd);
    @(negedge clk);
    idle_in();
    chk({nm, ".done"}, done, dn);
    chk({nm, ".stalled"}, stalled, st);
    chk({nm, ".empty_err"}, empty_err, ee);
    chk({nm, ".round"}, round_cnt, rd);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".opt_valid"}, opt_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [SIZE:0] e;
    bit dropped_round, keep_dec;
    int cyc;
    idle_in();

    // reset state
    do_reset();
    chk("rst.done", done, 0);
    chk("rst.busy", busy, 0);
    chk("rst.stalled", stalled, 0);
    chk("rst.empty_err", empty_err, 0);
    chk("rst.round", round_cnt, 0);
    chk("rst.opt_valid", opt_valid, 0);
    chk("rst.load_ready", load_ready, 1);

    // six markers only: round 1 after 6 cycles, round 2 stalls
    for (int i = 0; i < 6; i++) load(1, i);
    do_start();
    for (int i = 0; i < 12; i++)
      add(1, 0, 0, 0, 1, 1, 0, (i < 6) ? 0 : 1);
    run_vecs("t1");
    chk_end("t1.end", 1, 1, 0, 2);
`ifdef OPTQ_PERF_CNT_EN
    chk("t1.run_cycles", run_cycles, 12);
`endif

    // keep A, drop B; round 2 without drops stalls
    do_reset();
    load(1, 0); load(0, 5); load(0, 6);
    for (int i = 1; i < 6; i++) load(1, i);
    do_start();
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 1, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 0, 0, 0, 1, 1, 0, 1);
    add(1, 1, 1, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 1, 1, 0, 1);
    run_vecs("t2");
    chk_end("t2.end", 1, 1, 0, 2);

    // solved on an option handshake wins
    do_reset();
    load(1, 0); load(0, 3); load(1, 1);
    do_start();
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0, 0);
    run_vecs("t3");
    chk_end("t3.end", 1, 0, 0, 0);

    // start with empty queue
    do_reset();
    do_start();
    chk_end("t4.end", 1, 0, 1, 0);
    chk("t4.load_ready", load_ready, 0);

    // 65 loads into 64 entries; 65th (a marker) must be lost
    do_reset();
    for (int i = 0; i < 65; i++) begin
      @(negedge clk);
      idle_in();
      load_valid = 1;
      load_is_line = (i == 64);
      load_data = SIZE'(i % 8);
      chk($sformatf("t5.load_ready[%0d]", i), load_ready,
          (i < 64) ? 1 : 0);
      if (i < 64) mq.push_back({load_is_line, load_data});
    end
    do_start();
    for (int k = 0; k < 64; k++) begin
      add(1, 0, 0, 0, 1, 1, 0, 0);
      add(1, 1, 0, 0, 0, 1, 0, 0);
    end
    add(1, 0, 0, 0, 0, 1, 0, 0);
    run_vecs("t5");
    chk_end("t5.end", 1, 0, 1, 0);

    // rst while waiting on a verdict
    do_reset();
    load(1, 0); load(0, 3);
    do_start();
    add(1, 0, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0);
    run_vecs("t6");
    @(negedge clk);
    idle_in();
    chk("t6.wait_busy", busy, 1);
    chk("t6.wait_valid", opt_valid, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    mq.delete();
    chk("t6.busy", busy, 0);
    chk("t6.done", done, 0);
    chk("t6.opt_valid", opt_valid, 0);
    chk("t6.round", round_cnt, 0);
    chk("t6.load_ready", load_ready, 1);
    do_start();
    chk_end("t6.empty", 1, 0, 1, 0);

    // one drop every round until the round limit
    do_reset();
    load(1, 0);
    for (int j = 0; j < 16; j++) load(0, j % 8);
    for (int i = 1; i < 6; i++) load(1, i);
    do_start();
    dropped_round = 0;
    keep_dec = 0;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      idle_in();
      cyc++;
      if (done) break;
      opt_ready = 1;
      if (opt_valid) begin
        sb_pop($sformatf("t7[%0d]", cyc), e);
        if (e[SIZE]) begin
          mq.push_back(e);
          if (e[SIZE-1:0] == '0) dropped_round = 0;
        end else begin
          mheld = e;
          keep_dec = dropped_round;
          dropped_round = 1;
        end
      end else if (busy) begin
        resp_valid = 1;
        resp_keep = keep_dec;
        if (keep_dec) mq.push_back(mheld);
      end
    end
    chk("t7.in_time", (cyc < 3000) ? 1 : 0, 1);
    chk("t7.done", done, 1);
    chk("t7.stalled", stalled, 1);
    chk("t7.empty_err", empty_err, 0);
    chk("t7.round", round_cnt, 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
